// File: rtl/mem_bus_master_pkg.sv
// Shared encodings for the CPU-to-data-bus master: access sizes, fault causes,
// FSM states, plus small alignment and store-data helpers.
package mem_bus_master_pkg;

  localparam logic [1:0] SEL_BYTE    = 2'd0;
  localparam logic [1:0] SEL_HALF    = 2'd1;
  localparam logic [1:0] SEL_WORD    = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SEL_HALF: is_misaligned = addr_lo[0];
      SEL_WORD: is_misaligned = |addr_lo;
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

  // Bytes above the access size never reach the bus.
  function automatic logic [31:0] trim_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SEL_BYTE: trim_wdata = {24'h00_0000, data[7:0]};
      SEL_HALF: trim_wdata = {16'h0000, data[15:0]};
      default:  trim_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Shared data bus between the CPU bus master and its memory-mapped slaves.
interface mem_bus_master_if;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic [1:0]  sel_o;
  logic        rd_o;
  logic        we_o;
  logic        ack_i;

  modport master (output addr_o, data_o, sel_o, rd_o, we_o, input data_i, ack_i);
  modport slave  (input addr_o, data_o, sel_o, rd_o, we_o, output data_i, ack_i);
endinterface

// File: rtl/mem_bus_master_load_ext.sv
// Combinational sign/zero extension of right-justified load data by access size.
module mem_load_ext
  import mem_bus_master_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  // Replicate the top bit of the accessed field only when a signed load asks for it.
  always_comb begin
    result = data;
    case (size)
      SEL_BYTE: result = {{24{sign_ext & data[7]}}, data[7:0]};
      SEL_HALF: result = {{16{sign_ext & data[15]}}, data[15:0]};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// Bridges one CPU load/store at a time onto the shared data bus, with
// alignment/illegal-access checks and a bus timeout.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [1:0]        cpu_size_i,
  input  logic              cpu_signed_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_we_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              cpu_fault_o,
  output logic [1:0]        cpu_fault_cause_o,
  mem_bus_master_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             req_s;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_r;
  logic [31:0]      data_r;
  logic [1:0]       size_r;
  logic             signed_r;
  logic             dir_rd_r;
  logic             rd_r;
  logic             we_r;
  logic [31:0]      ext_s;

  assign req_s       = cpu_rd_i | cpu_we_i;
  assign cpu_stall_o = rst & req_s & (state_r != ST_DONE) & (state_r != ST_ERR);

  assign bus.addr_o = addr_r;
  assign bus.data_o = data_r;
  assign bus.sel_o  = size_r;
  assign bus.rd_o   = rd_r;
  assign bus.we_o   = we_r;

  mem_load_ext u_load_ext (
    .data     (bus.data_i),
    .size     (size_r),
    .sign_ext (signed_r),
    .result   (ext_s)
  );

  // Access FSM: latch request, run the bus phase with timeout, report done/fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= ST_IDLE;
      cnt_r             <= '0;
      addr_r            <= 32'h0000_0000;
      data_r            <= 32'h0000_0000;
      size_r            <= SEL_BYTE;
      signed_r          <= 1'b0;
      dir_rd_r          <= 1'b0;
      rd_r              <= 1'b0;
      we_r              <= 1'b0;
      cpu_rdata_o       <= 32'h0000_0000;
      cpu_fault_o       <= 1'b0;
      cpu_fault_cause_o <= FAULT_NONE;
    end else begin
      cpu_fault_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            addr_r   <= cpu_addr_i;
            data_r   <= trim_wdata(cpu_size_i, cpu_wdata_i);
            size_r   <= cpu_size_i;
            signed_r <= cpu_signed_i;
            dir_rd_r <= cpu_rd_i;
            if ((cpu_rd_i & cpu_we_i) || (cpu_size_i == SEL_ILLEGAL)) begin
              state_r           <= ST_ERR;
              cpu_fault_o       <= 1'b1;
              cpu_fault_cause_o <= FAULT_ILLEGAL;
            end else if (is_misaligned(cpu_size_i, cpu_addr_i[1:0])) begin
              state_r           <= ST_ERR;
              cpu_fault_o       <= 1'b1;
              cpu_fault_cause_o <= FAULT_MISALIGN;
            end else begin
              state_r <= ST_BUS;
              rd_r    <= cpu_rd_i;
              we_r    <= cpu_we_i;
            end
          end
        end
        ST_BUS: begin
          if (bus.ack_i) begin
            // A load withdrawn mid-access still finishes on the bus but is not returned.
            if (dir_rd_r && cpu_rd_i) begin
              cpu_rdata_o <= ext_s;
            end
            state_r <= ST_DONE;
            rd_r    <= 1'b0;
            we_r    <= 1'b0;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r           <= ST_ERR;
            rd_r              <= 1'b0;
            we_r              <= 1'b0;
            cnt_r             <= '0;
            cpu_fault_o       <= 1'b1;
            cpu_fault_cause_o <= FAULT_TIMEOUT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        ST_ERR:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized self-checking bench for mem_bus_master against a transaction-level model.
module tb_mem_bus_master;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [1:0]  cpu_size_i;
  logic        cpu_signed_i;
  logic        cpu_rd_i;
  logic        cpu_we_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        cpu_fault_o;
  logic [1:0]  cpu_fault_cause_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  logic [31:0] slave_val = 32'h0;

  logic [31:0] exp_rdata = 32'h0;
  logic [1:0]  exp_cause = 2'd0;

  mem_bus_master_if bus_if ();

  mem_bus_master #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_addr_i        (cpu_addr_i),
    .cpu_wdata_i       (cpu_wdata_i),
    .cpu_size_i        (cpu_size_i),
    .cpu_signed_i      (cpu_signed_i),
    .cpu_rd_i          (cpu_rd_i),
    .cpu_we_i          (cpu_we_i),
    .cpu_rdata_o       (cpu_rdata_o),
    .cpu_stall_o       (cpu_stall_o),
    .cpu_fault_o       (cpu_fault_o),
    .cpu_fault_cause_o (cpu_fault_cause_o),
    .bus               (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    if (size == 2'd0) return 32'h0000_00FF;
    if (size == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size, input logic sgn);
    if (size == 2'd0) return (sgn && v >= 32'h80) ? v + 32'hFFFF_FF00 : v;
    if (size == 2'd1) return (sgn && v >= 32'h8000) ? v + 32'hFFFF_0000 : v;
    return v;
  endfunction

  // Slave: acknowledges after ack_delay wait cycles; delay 0 means ack tied high.
  always @(posedge clk) wait_cnt <= (bus_if.rd_o | bus_if.we_o) ? wait_cnt + 32'd1 : 32'd0;
  assign bus_if.ack_i  = (ack_delay == 0) ? 1'b1 : ((bus_if.rd_o | bus_if.we_o) && (wait_cnt == ack_delay));
  assign bus_if.data_i = slave_val & size_mask(bus_if.sel_o);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One CPU access, started just after a rising edge; returns just after the edge that ends DONE/ERR.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                           input logic sgn, input logic rd, input logic we,
                           input int unsigned delay, input logic [31:0] sval);
    logic [1:0]  fcause;
    int unsigned exp_strobes, n_stall, n_rd, n_we;
    bit          done;
    if ((rd && we) || size == 2'd3) fcause = 2'd3;
    else if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) fcause = 2'd1;
    else if (delay >= TIMEOUT) fcause = 2'd2;
    else fcause = 2'd0;
    if (fcause == 2'd1 || fcause == 2'd3) exp_strobes = 0;
    else if (fcause == 2'd2) exp_strobes = TIMEOUT;
    else exp_strobes = delay + 1;
    if (fcause != 2'd0) exp_cause = fcause;
    else if (rd) exp_rdata = extend(sval & size_mask(size), size, sgn);

    cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_size_i = size; cpu_signed_i = sgn;
    cpu_rd_i = rd; cpu_we_i = we; ack_delay = delay; slave_val = sval;
    n_stall = 0; n_rd = 0; n_we = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_if.rd_o || bus_if.we_o) begin
        if (n_rd + n_we == 0) begin
          check_eq("bus_addr", bus_if.addr_o, addr);
          check_eq("bus_sel", {30'd0, bus_if.sel_o}, {30'd0, size});
          if (we) check_eq("bus_wdata", bus_if.data_o, wdata & size_mask(size));
        end
        if (bus_if.rd_o) n_rd++;
        if (bus_if.we_o) n_we++;
      end
      if (cpu_stall_o) n_stall++;
      else begin
        done = 1;
        check_eq("fault_pulse", {31'd0, cpu_fault_o}, {31'd0, fcause != 2'd0});
        check_eq("fault_cause", {30'd0, cpu_fault_cause_o}, {30'd0, exp_cause});
        check_eq("rdata", cpu_rdata_o, exp_rdata);
      end
    end
    if (!done) check_eq("stall_release", 32'd0, 32'd1);
    check_eq("stall_cycles", n_stall, exp_strobes + 1);
    check_eq("rd_cycles", n_rd, rd && !we ? exp_strobes : 0);
    check_eq("we_cycles", n_we, we && !rd ? exp_strobes : 0);
    @(posedge clk); #1;
    cpu_rd_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic        r, w;
    int unsigned pick;
    rst = 1'b0;
    cpu_addr_i = 32'h4; cpu_wdata_i = 32'h0; cpu_size_i = 2'd2; cpu_signed_i = 1'b0;
    cpu_rd_i = 1'b1; cpu_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_rd", {31'd0, bus_if.rd_o}, 32'd0);
    check_eq("rst_we", {31'd0, bus_if.we_o}, 32'd0);
    check_eq("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    check_eq("rst_fault", {31'd0, cpu_fault_o}, 32'd0);
    check_eq("rst_cause", {30'd0, cpu_fault_cause_o}, 32'd0);
    check_eq("rst_rdata", cpu_rdata_o, 32'd0);
    check_eq("rst_addr", bus_if.addr_o, 32'd0);
    cpu_rd_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_access(32'h0000_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 0, 32'h8765_4321);
    do_access(32'h0000_0103, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 0, 32'h1234_5680);
    do_access(32'h0000_0103, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1, 32'h1234_5680);
    do_access(32'h0000_0012, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b0, 1'b1, 3, 32'h0);
    do_access(32'h0000_0006, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 0, 32'h5555_5555);
    do_access(32'h0000_0008, 32'h0, 2'd3, 1'b0, 1'b1, 1'b0, 0, 32'h5555_5555);
    do_access(32'h0000_0008, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1, 0, 32'h5555_5555);
    do_access(32'h0000_0020, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 7, 32'hAAAA_AAAA);
    do_access(32'h0000_0022, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 3, 32'h0000_9ABC);

    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
      pick = $urandom_range(0, 19);
      r = (pick < 10) || (pick == 19);
      w = (pick >= 9);
      do_access(a, $urandom, sz, 1'($urandom_range(0, 1)), r, w, $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of a bus read: strobes and stall must drop at once.
    cpu_addr_i = 32'h40; cpu_size_i = 2'd2; cpu_signed_i = 1'b0;
    cpu_rd_i = 1'b1; cpu_we_i = 1'b0; ack_delay = 3; slave_val = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_rd", {31'd0, bus_if.rd_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rd", {31'd0, bus_if.rd_o}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    check_eq("mid_rst_fault", {31'd0, cpu_fault_o}, 32'd0);
    cpu_rd_i = 1'b0;
    exp_rdata = 32'h0; exp_cause = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(32'h0000_0080, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1, 32'hCAFE_0123);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
